// File: rtl/stim_pkg.sv
// Shared types and constants for the exhaustive stimulus sequencer.
// Also holds the MISR step function used by the optional signature logic.
package stim_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } stim_state_t;

    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [15:0] data);
        return {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ data;
    endfunction

endpackage

// File: rtl/stim_misr.sv
// 16-bit MISR compacting accepted {pattern, response} records into a signature.
// Latency: one cycle per shift. Backpressure: none, it shifts only on shift_en.
// init reloads the seed and takes priority over shift_en.
module stim_misr
    import stim_pkg::*;
(
    input  logic        CK,
    input  logic        reset,
    input  logic        init,
    input  logic        shift_en,
    input  logic [15:0] data,
    output logic [15:0] sig
);

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            sig <= MISR_SEED;
        end else if (init) begin
            sig <= MISR_SEED;
        end else if (shift_en) begin
            sig <= misr_step(sig, data);
        end
    end

endmodule

// File: rtl/stim_sequencer.sv
// Exhaustive stimulus sweep 0..2^N_WIDTH-1 with settle time and one record per pattern.
// Latency: SETTLE cycles from pattern drive to rec_valid; SETTLE+1 cycles per pattern at full rate.
// Backpressure: rec_valid/rec_ready; pattern and record hold while rec_ready is low. Option: STIM_MISR_SIGNATURE_EN.
module stim_sequencer
    import stim_pkg::*;
#(
    parameter int N_WIDTH   = 3,
    parameter int OUT_WIDTH = 1,
    parameter int SETTLE    = 1
) (
    input  logic                 CK,
    input  logic                 reset,
    input  logic                 start,
    output logic [N_WIDTH-1:0]   pattern_o,
    input  logic [OUT_WIDTH-1:0] dut_out_i,
    output logic                 rec_valid,
    input  logic                 rec_ready,
    output logic [N_WIDTH-1:0]   rec_pattern,
    output logic [OUT_WIDTH-1:0] rec_response,
    output logic                 busy,
    output logic                 done
`ifdef STIM_MISR_SIGNATURE_EN
    ,
    output logic [15:0]          signature_o,
    output logic                 signature_valid
`endif
);

    localparam int                 CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [N_WIDTH-1:0] PAT_LAST = '1;

    stim_state_t      state;
    stim_state_t      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             start_acc;
    logic             sample;
    logic             hs;
    logic             last;

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        sample    = 1'b0;
        hs        = 1'b0;
        last      = (pattern_o == PAT_LAST);
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt == '0) begin
                    sample    = 1'b1;
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (rec_valid && rec_ready) begin
                    hs        = 1'b1;
                    state_nxt = last ? DONE : DRIVE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // pattern_o moves only on the EMIT->DRIVE handshake so the DUT input never glitches mid-settle
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            pattern_o    <= '0;
            cnt          <= '0;
            rec_valid    <= 1'b0;
            rec_pattern  <= '0;
            rec_response <= '0;
        end else begin
            if (start_acc) begin
                pattern_o <= '0;
                cnt       <= CNT_LOAD;
            end
            if (state == DRIVE && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (sample) begin
                rec_valid    <= 1'b1;
                rec_pattern  <= pattern_o;
                rec_response <= dut_out_i;
            end
            if (hs) begin
                rec_valid <= 1'b0;
                if (!last) begin
                    pattern_o <= pattern_o + N_WIDTH'(1);
                    cnt       <= CNT_LOAD;
                end
            end
        end
    end

    assign busy = (state == DRIVE) || (state == EMIT);
    assign done = (state == DONE);

`ifdef STIM_MISR_SIGNATURE_EN
    stim_misr u_misr (
        .CK       (CK),
        .reset    (reset),
        .init     (start_acc),
        .shift_en (hs),
        .data     (16'({rec_pattern, rec_response})),
        .sig      (signature_o)
    );

    assign signature_valid = done;
`endif

endmodule

// File: tb/tb_stim_sequencer.sv
// Directed bench for stim_sequencer: default instance with parity DUT, plus SETTLE=3 instance with 2-cycle response delay.
module tb_stim_sequencer;

    logic       CK = 1'b0;
    logic       reset;
    logic       start_a, start_b;
    logic       rec_ready_a, rec_ready_b;
    logic       flip_en;
    logic [2:0] flip_pat;

    logic [2:0] pattern_a, rec_pattern_a, pattern_b, rec_pattern_b;
    logic       dut_out_a, dut_out_b, rec_response_a, rec_response_b;
    logic       rec_valid_a, rec_valid_b, busy_a, busy_b, done_a, done_b;
    logic       d1, d2;
`ifdef STIM_MISR_SIGNATURE_EN
    logic [15:0] sig_a, sig_b;
    logic        sigv_a, sigv_b;
`endif

    int total = 0;
    int bad   = 0;
    logic [7:0] par_tab = 8'b1001_0110;
    logic [3:0] recs_a[$];
    logic [3:0] recs_b[$];

    always #5 CK = ~CK;

    assign dut_out_a = (^pattern_a) ^ (flip_en && (pattern_a == flip_pat));

    always @(posedge CK) begin
        d1 <= ^pattern_b;
        d2 <= d1;
    end
    assign dut_out_b = d2;

    stim_sequencer dut_a (
        .CK           (CK),
        .reset        (reset),
        .start        (start_a),
        .pattern_o    (pattern_a),
        .dut_out_i    (dut_out_a),
        .rec_valid    (rec_valid_a),
        .rec_ready    (rec_ready_a),
        .rec_pattern  (rec_pattern_a),
        .rec_response (rec_response_a),
        .busy         (busy_a),
        .done         (done_a)
`ifdef STIM_MISR_SIGNATURE_EN
        , .signature_o(sig_a), .signature_valid(sigv_a)
`endif
    );

    stim_sequencer #(.N_WIDTH(3), .OUT_WIDTH(1), .SETTLE(3)) dut_b (
        .CK           (CK),
        .reset        (reset),
        .start        (start_b),
        .pattern_o    (pattern_b),
        .dut_out_i    (dut_out_b),
        .rec_valid    (rec_valid_b),
        .rec_ready    (rec_ready_b),
        .rec_pattern  (rec_pattern_b),
        .rec_response (rec_response_b),
        .busy         (busy_b),
        .done         (done_b)
`ifdef STIM_MISR_SIGNATURE_EN
        , .signature_o(sig_b), .signature_valid(sigv_b)
`endif
    );

    // A record is accepted at the posedge following a negedge that sees valid && ready.
    always @(negedge CK) begin
        if (rec_valid_a && rec_ready_a) recs_a.push_back({rec_pattern_a, rec_response_a});
        if (rec_valid_b && rec_ready_b) recs_b.push_back({rec_pattern_b, rec_response_b});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_recs(input string tag, input int is_b);
        int sz;
        logic [3:0] r;
        sz = is_b ? recs_b.size() : recs_a.size();
        chk({tag, "_count"}, sz, 8);
        for (int i = 0; i < 8 && i < sz; i++) begin
            r = is_b ? recs_b[i] : recs_a[i];
            chk({tag, "_rec"}, r, {i[2:0], par_tab[i]});
        end
    endtask

`ifdef STIM_MISR_SIGNATURE_EN
    function automatic logic [15:0] sig_model(input logic [7:0] flip_mask);
        logic [15:0] s;
        s = 16'hFFFF;
        for (int i = 0; i < 8; i++) begin
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {12'h000, i[2:0], par_tab[i] ^ flip_mask[i]};
        end
        return s;
    endfunction
`endif

    // Runs one sweep on dut_a; n counts edges after the start edge until done is seen.
    task automatic sweep_a(input int stall_pat, input int pulse_pat, input int rst_pat, output int n);
        bit stalled = 0;
        bit pulsed  = 0;
        recs_a.delete();
        start_a = 1'b1;
        @(posedge CK); #1;
        start_a = 1'b0;
        n = 0;
        chk("start_done_clr", done_a, 0);
        chk("start_busy", busy_a, 1);
        chk("start_pat0", pattern_a, 0);
        while (!done_a && n < 400) begin
            if (rst_pat >= 0 && rec_valid_a && rec_pattern_a == 3'(rst_pat)) begin
                reset = 1'b0;
                #1;
                chk("rst_async_outs", {pattern_a, rec_valid_a, rec_pattern_a, rec_response_a, busy_a, done_a}, 0);
                return;
            end
            if (pulse_pat >= 0 && !pulsed && busy_a && pattern_a == 3'(pulse_pat)) begin
                pulsed  = 1;
                start_a = 1'b1;
            end
            if (stall_pat >= 0 && !stalled && rec_valid_a && rec_pattern_a == 3'(stall_pat)) begin
                stalled     = 1;
                rec_ready_a = 1'b0;
                repeat (5) begin
                    @(posedge CK); #1;
                    n++;
                    chk("stall_vld", rec_valid_a, 1);
                    chk("stall_rec", {rec_pattern_a, rec_response_a}, 4'b0110);
                    chk("stall_pat_o", pattern_a, 3);
                end
                rec_ready_a = 1'b1;
            end
            @(posedge CK); #1;
            n++;
            start_a = 1'b0;
        end
        chk("sweep_done", done_a, 1);
        chk("sweep_busy_end", busy_a, 0);
    endtask

    initial begin
        int n;
`ifdef STIM_MISR_SIGNATURE_EN
        logic [15:0] good_sig;
`endif
        reset       = 1'b0;
        start_a     = 1'b0;
        start_b     = 1'b0;
        rec_ready_a = 1'b1;
        rec_ready_b = 1'b1;
        flip_en     = 1'b0;
        flip_pat    = 3'd4;
        repeat (3) @(posedge CK);
        #1;
        chk("reset_outs", {pattern_a, rec_valid_a, rec_pattern_a, rec_response_a, busy_a, done_a}, 0);
        reset = 1'b1;
        repeat (2) @(posedge CK);
        #1;
        chk("idle_no_start", {busy_a, done_a, rec_valid_a}, 0);

        // plain sweep with parity DUT
        sweep_a(-1, -1, -1, n);
        chk("sweep_cycles", n, 16);
        check_recs("plain", 0);
`ifdef STIM_MISR_SIGNATURE_EN
        good_sig = sig_model(8'h00);
        chk("sig_plain", sig_a, good_sig);
        chk("sig_valid", sigv_a, 1);
        repeat (3) @(posedge CK);
        #1;
        chk("sig_frozen", sig_a, good_sig);
`endif

        // backpressure on pattern 3 (restart from DONE)
        sweep_a(3, -1, -1, n);
        chk("stall_cycles", n, 21);
        check_recs("stall", 0);

        // start pulsed mid-sweep is ignored
        sweep_a(-1, 2, -1, n);
        chk("pulse_cycles", n, 16);
        check_recs("pulse", 0);

        // reset in EMIT on pattern 5
        sweep_a(-1, -1, 5, n);
        chk("rst_rec_count", recs_a.size(), 5);
        @(negedge CK);
        reset = 1'b1;
        repeat (5) @(posedge CK);
        #1;
        chk("post_rst_idle", {pattern_a, rec_valid_a, busy_a, done_a}, 0);
        sweep_a(-1, -1, -1, n);
        chk("post_rst_cycles", n, 16);
        check_recs("post_rst", 0);

`ifdef STIM_MISR_SIGNATURE_EN
        chk("sig_post_rst", sig_a, good_sig);
        flip_en = 1'b1;
        sweep_a(-1, -1, -1, n);
        flip_en = 1'b0;
        chk("sig_flip_model", sig_a, sig_model(8'h10));
        chk("sig_flip_differs", (sig_a != good_sig), 1);
`endif

        // SETTLE=3 with 2-cycle response delay
        start_b = 1'b1;
        @(posedge CK); #1;
        start_b = 1'b0;
        n = 0;
        while (!done_b && n < 400) begin
            @(posedge CK); #1;
            n++;
        end
        chk("settle3_done", done_b, 1);
        chk("settle3_cycles", n, 32);
        check_recs("settle3", 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stim_sequencer.md
Name: stim_sequencer

Overview:
- Exhaustive stimulus stage that sits directly upstream of a benchmark DUT under trojan-detection test.
- Drives every input pattern 0 .. 2^N_WIDTH-1 in ascending order on the DUT inputs.
- After a programmable settle time, samples the DUT response and emits one {pattern, response} record per pattern to a downstream logger over a valid/ready handshake.
- Replaces free-running delay-based stimulus with a deterministic, backpressure-aware sequence.

Parameters:
- N_WIDTH, 3, DUT input pattern width; 1..12.
- OUT_WIDTH, 1, DUT output width; N_WIDTH+OUT_WIDTH <= 16.
- SETTLE, 1, cycles a pattern is held before the response is sampled; >= 1.

Ports:
- CK  input  1  single clock; all state updates on posedge CK.
- reset  input  1  asynchronous, active-low reset; asserted (0) clears all state immediately.
- start  input  1  begin a sweep; sampled only in IDLE or DONE.
- pattern_o  output  N_WIDTH  stimulus driven to DUT inputs, bit 0 = N[0] (MSB-first vector ordering).
- dut_out_i  input  OUT_WIDTH  DUT response.
- rec_valid  output  1  record available.
- rec_ready  input  1  downstream accepts record.
- rec_pattern  output  N_WIDTH  pattern of current record.
- rec_response  output  OUT_WIDTH  sampled response.
- busy  output  1  high in DRIVE or EMIT.
- done  output  1  sweep complete; sticky until next start or reset.

Behaviour:
- Reset values: pattern_o=0, rec_valid=0, rec_pattern=0, rec_response=0, busy=0, done=0, state=IDLE, settle counter=0.
- Reset asserted mid-sweep aborts immediately; no partial record survives; after release the block waits in IDLE for start.
- FSM states: IDLE, DRIVE, EMIT, DONE.
- IDLE/DONE with start=1 at edge k:
  - state becomes DRIVE, pattern_o=0, cnt=SETTLE-1.
  - done clears, busy sets.
- DRIVE:
  - each edge, cnt decrements.
  - at the edge where cnt==0: rec_response<=dut_out_i, rec_pattern<=pattern_o, rec_valid<=1, state becomes EMIT.
  - net effect: DRIVE lasts exactly SETTLE cycles, and rec_valid first rises at edge k+SETTLE.
- EMIT:
  - rec_valid, rec_pattern and rec_response are held stable until rec_valid&&rec_ready at an edge.
  - on that handshake, rec_valid<=0.
  - if pattern_o == all-ones: state becomes DONE, done<=1, busy<=0, and pattern_o holds its last value.
  - otherwise: pattern_o<=pattern_o+1, cnt=SETTLE-1, state becomes DRIVE.
- pattern_o changes only on the EMIT→DRIVE transition, so the DUT input is stable for at least SETTLE+1 cycles.
- Throughput with rec_ready tied high: SETTLE+1 cycles per pattern.
- Full sweep timing: done rises 2^N_WIDTH*(SETTLE+1) cycles after the start edge.
- start while busy is ignored, with no effect on state or counters.
- start in DONE restarts the sweep from pattern 0.
- rec_ready outside EMIT is ignored.
- Pattern counter is N_WIDTH bits. Wrap-around is never used: the all-ones pattern terminates the sweep.

Optional Feature:
- Macro: STIM_MISR_SIGNATURE_EN.
- Defined:
  - extra output signature_o[15:0] and signature_valid (equal to done).
  - 16-bit MISR, polynomial 16'h1021; reset and reload on accepted start to 16'hFFFF.
  - per accepted record: sig <= (sig<<1) ^ (sig[15] ? 16'h1021 : 0) ^ zero-extended {rec_pattern, rec_response}.
  - signature_o is frozen in DONE.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package stim_pkg:
  - state enum stim_state_t {IDLE, DRIVE, EMIT, DONE}.
  - MISR_POLY=16'h1021, MISR_SEED=16'hFFFF.
- Sub-module stim_misr, instantiated only under the macro:
  - inputs: CK, reset, init, shift_en, data[15:0].
  - output: sig[15:0].

Test Plan:
- Default parameters, rec_ready=1, dut_out_i=^pattern_o (parity DUT) → 8 records 000/0, 001/1, 010/1, 011/0, 100/1, 101/0, 110/0, 111/1; done rises 16 cycles after the start edge; busy=0 afterwards.
- rec_ready low for 5 cycles on pattern 3 → rec_valid, rec_pattern=3'b011 and rec_response stay stable; pattern_o stays 3; no record is lost or duplicated; total sweep is 21 cycles.
- SETTLE=3, DUT response delayed 2 cycles → every sampled response is correct; each pattern takes 4 cycles; done at 32 cycles.
- start pulsed again during the sweep at pattern 2 → ignored; sequence continues to 7; start in DONE → sweep restarts at 0 and done clears at the same edge.
- reset driven low at pattern 5 while in EMIT → all outputs 0 asynchronously, before the next CK edge; after release, the block idles until start; the next sweep begins at 0.
- STIM_MISR_SIGNATURE_EN defined, parity DUT → signature_o equals the software model value; a single flipped response bit changes the signature.
